calc_driver: RTL

Clocked initiator for the switch-driven calculator front end. It accepts an operand/opcode request over a valid/ready handshake and replays it on the calculator's `enter`/`data_in` interface as correctly spaced pulses. It then samples the calculator's `result` and returns it over a valid/ready response handshake. It sits between a host-side sequencer (bench, UART bridge, soft CPU) and the calculator, replacing manual switch/button operation.

---
 rtl/calc_driver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/calc_driver.sv
`default_nettype none
// ============================================================================
// Module   : calc_driver
// Brief    : Replays a valid/ready request on the calculator's enter/data_in
//            pins as spaced pulses, then returns the captured result.
//            Optional feature macro: CALC_DRIVER_ZERO_EN (adds rsp_zero).
// Revision : 1.0
// ============================================================================
module calc_driver #(
  parameter int SETUP = 2,
  parameter int PULSE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
`ifdef CALC_DRIVER_ZERO_EN
  output logic       rsp_zero,
`endif
  output logic       calc_reset,
  output logic       calc_enter,
  output logic [7:0] calc_data,
  input  logic [7:0] calc_result
);

  localparam logic [7:0] SETUP_TC = 8'(SETUP - 1);
  localparam logic [7:0] PULSE_TC = 8'(PULSE - 1);

  typedef enum logic [2:0] {RST_HOLD, PRIME, IDLE, RUN, CAPTURE, RESP} state_t;
  typedef enum logic [1:0] {SEG_SETUP, SEG_HIGH, SEG_LOW} seg_t;

  state_t     state_q;
  seg_t       seg_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [1:0] phase_q;
  logic [7:0] b_q;
  logic [3:0] op_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_result_q;
  logic       calc_reset_q;
  logic       calc_enter_q;
  logic [7:0] calc_data_q;
  logic       seg_tc;
  logic       pulse_done;
`ifdef CALC_DRIVER_ZERO_EN
  logic       rsp_zero_q;
`endif

  assign cnt_d      = cnt_q + 8'd1;
  assign seg_tc     = (seg_q == SEG_SETUP) ? (cnt_q == SETUP_TC) : (cnt_q == PULSE_TC);
  assign pulse_done = (seg_q == SEG_LOW) && seg_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_HOLD;
      seg_q        <= SEG_SETUP;
      cnt_q        <= '0;
      phase_q      <= '0;
      b_q          <= '0;
      op_q         <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      calc_reset_q <= 1'b1;
      calc_enter_q <= 1'b0;
      calc_data_q  <= '0;
`ifdef CALC_DRIVER_ZERO_EN
      rsp_zero_q   <= 1'b0;
`endif
    end else begin
      // Pulse sequencer: setup (enter low), high, low; always ends back in SEG_SETUP with cnt 0
      if (state_q == PRIME || state_q == RUN) begin
        if (seg_tc) begin
          cnt_q <= '0;
          case (seg_q)
            SEG_SETUP: begin
              seg_q        <= SEG_HIGH;
              calc_enter_q <= 1'b1;
            end
            SEG_HIGH: begin
              seg_q        <= SEG_LOW;
              calc_enter_q <= 1'b0;
            end
            default: seg_q <= SEG_SETUP;
          endcase
        end else begin
          cnt_q <= cnt_d;
        end
      end

      case (state_q)
        RST_HOLD: begin
          calc_reset_q <= 1'b0;
          phase_q      <= '0;
          state_q      <= PRIME;
        end
        PRIME: begin
          // Three zero-data pulses walk the calculator S0->S3 and park it there
          if (pulse_done) begin
            phase_q <= phase_q + 2'd1;
            if (phase_q == 2'd2) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            b_q         <= req_b;
            op_q        <= req_op;
            calc_data_q <= req_a;
            phase_q     <= '0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (pulse_done) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd0:       calc_data_q <= b_q;
              2'd1, 2'd2: calc_data_q <= {4'h0, op_q};
              default:    state_q     <= CAPTURE;
            endcase
          end
        end
        CAPTURE: begin
          rsp_result_q <= calc_result;
`ifdef CALC_DRIVER_ZERO_EN
          rsp_zero_q   <= (calc_result == 8'h00);
`endif
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= RST_HOLD;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign calc_reset = calc_reset_q;
  assign calc_enter = calc_enter_q;
  assign calc_data  = calc_data_q;
`ifdef CALC_DRIVER_ZERO_EN
  assign rsp_zero   = rsp_zero_q;
`endif

endmodule

`default_nettype wire
